// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W       = 32;
    localparam int MEM_DATA_W       = 32;
    localparam int MEM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    // Registered bus command; widths follow the package defaults used by the interface.
    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_W-1:0]     addr;
        logic [MEM_DATA_W-1:0]     wdata;
        logic [MEM_DATA_W/8-1:0]   wstrb;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory bus seen by the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until ack; bus command held until m_ready.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) ();

    // fetch port (read only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    // data port (read/write)
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic                d_ack;
    logic [DATA_W-1:0]   d_rdata;

    // shared memory bus
    logic                m_req;
    logic                m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_ready;
    logic                m_rvalid;
    logic [DATA_W-1:0]   m_rdata;

    logic err;

    // arbiter side
    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata,
        output err
    );

    // requester / memory side
    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata,
        input  err
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selection: D over I, with I forced once D has won STARVE_LIMIT times in a row.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller samples the result only when it can accept a new command.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = MEM_STARVE_LIMIT,
    parameter int CNT_W        = 3
) (
    input  logic             i_req_i,
    input  logic             d_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             grant_valid_o,
    output arb_owner_t       owner_o
);

    // D wins unless I is waiting and D has already used up its run of consecutive grants;
    // a counter tied to zero therefore degenerates to plain D-over-I priority.
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        owner_o       = OWN_I;
        if (d_req_i && !(i_req_i && (starve_cnt_i == CNT_W'(STARVE_LIMIT)))) begin
            owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory bus between fetch (I, read) and data (D, read/write) ports.
// Latency: request seen in cycle 0, m_req cycle 1, ack cycle 3 on a zero-wait bus; 1 access per 4 cycles.
// Backpressure: command held on m_req until m_ready; requesters stall on req until their ack.
// Optional: MEM_ARB_STARVE_GUARD_EN adds a starvation counter that forces an I grant after STARVE_LIMIT D wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q,   state_d;
    arb_owner_t            owner_q,   owner_d;
    mem_cmd_t              cmd_q,     cmd_d;
    logic [MEM_DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [MEM_DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q,     err_d;

    logic                  grant_valid;
    arb_owner_t            grant_owner;
    logic [CNT_W-1:0]      starve_cnt;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_req_i       (bus.i_req),
        .d_req_i       (bus.d_req),
        .starve_cnt_i  (starve_cnt),
        .grant_valid_o (grant_valid),
        .owner_o       (grant_owner)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Count D grants that leave I waiting; any I grant or uncontested D grant restarts the run.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((state_q == ST_IDLE) && grant_valid) begin
            if ((grant_owner == OWN_D) && bus.i_req) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve_cnt = starve_cnt_q;
`else
    assign starve_cnt = '0;
`endif

    // Sequence grant -> issue -> wait for response -> ack; latch command at grant and data at response.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        // any response outside WAIT is a protocol violation (includes one overlapping acceptance)
        err_d     = err_q | (bus.m_rvalid & (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_ISSUE;
                    owner_d = grant_owner;
                    if (grant_owner == OWN_D) begin
                        cmd_d.we    = bus.d_we;
                        cmd_d.addr  = bus.d_addr;
                        cmd_d.wdata = bus.d_we ? bus.d_wdata : '0;
                        cmd_d.wstrb = bus.d_we ? bus.d_wstrb : '0;
                    end else begin
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = bus.i_addr;
                        cmd_d.wdata = '0;
                        cmd_d.wstrb = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.m_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_rvalid) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = bus.m_rdata;
                    end else if (!cmd_q.we) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            ST_DONE: begin
                // requests deliberately not sampled here: the acked requester still shows its old req
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            cmd_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = (state_q == ST_ISSUE);
    assign bus.m_we    = cmd_q.we;
    assign bus.m_addr  = cmd_q.addr;
    assign bus.m_wdata = cmd_q.wdata;
    assign bus.m_wstrb = cmd_q.wstrb;

    assign bus.i_ack   = (state_q == ST_DONE) && (owner_q == OWN_I);
    assign bus.d_ack   = (state_q == ST_DONE) && (owner_q == OWN_D);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench: transaction-level requesters, a memory model behind the bus, and a grant-order model.
// Latency: checks cycle-exact m_req/ack timing against the issue/wait/ack sequence.
// Backpressure: the bus responder inserts random or fixed m_ready/m_rvalid delays.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // memory behind the bus
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + ($urandom_range(0, 15) << 2);
    endfunction

    // requester models
    bit          i_pend, d_pend, d_we_v;
    logic [31:0] i_addr_v, d_addr_v, d_wdata_v;
    logic [3:0]  d_wstrb_v;
    int          pct_i, pct_d;

    // bus responder knobs
    bit zero_wait, noise;
    int fixed_ready, fixed_rv;

    // expected behaviour
    bit          exp_mreq, exp_iack, exp_dack, exp_err;
    logic [31:0] exp_irdata, exp_drdata;
    bit          own_d, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          arb_free, in_wait;
    int          free_cnt, ready_cnt, rv_cnt, d_streak;
    bit          grant_log[$];
    int          cyc, i_ack_cyc, d_ack_cyc;

    function automatic int pick_delay(input int fixed);
        if (zero_wait) return 0;
        if (fixed >= 0) return fixed;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic drive_idle();
        bus.i_req    = 1'b0;
        bus.i_addr   = 32'h0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = 32'h0;
        bus.d_wdata  = 32'h0;
        bus.d_wstrb  = 4'h0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = 32'h0;
    endtask

    task automatic bench_reset();
        rst = 1'b1;
        drive_idle();
        i_pend = 1'b0; d_pend = 1'b0;
        pct_i = 0; pct_d = 0;
        zero_wait = 1'b0; noise = 1'b0; fixed_ready = -1; fixed_rv = -1;
        exp_mreq = 1'b0; exp_iack = 1'b0; exp_dack = 1'b0; exp_err = 1'b0;
        exp_irdata = 32'h0; exp_drdata = 32'h0;
        arb_free = 1'b1; in_wait = 1'b0; free_cnt = 0; d_streak = 0;
        grant_log.delete();
        i_ack_cyc = -1; d_ack_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One iteration per cycle: compare at negedge, then drive inputs for the next rising edge.
    task automatic run(input int ncyc);
        logic [31:0] w;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cyc++;
            if (free_cnt > 0) begin
                free_cnt--;
                if (free_cnt == 0) arb_free = 1'b1;
            end

            chk("m_req", 64'(bus.m_req), 64'(exp_mreq));
            if (exp_mreq) begin
                chk("m_we",    64'(bus.m_we),    64'(exp_we));
                chk("m_addr",  64'(bus.m_addr),  64'(exp_addr));
                chk("m_wdata", 64'(bus.m_wdata), 64'(exp_wdata));
                chk("m_wstrb", 64'(bus.m_wstrb), 64'(exp_wstrb));
            end
            chk("i_ack",   64'(bus.i_ack),   64'(exp_iack));
            chk("d_ack",   64'(bus.d_ack),   64'(exp_dack));
            chk("i_rdata", 64'(bus.i_rdata), 64'(exp_irdata));
            chk("d_rdata", 64'(bus.d_rdata), 64'(exp_drdata));
            chk("err",     64'(bus.err),     64'(exp_err));

            if (exp_iack) begin
                i_pend = 1'b0;
                if (i_ack_cyc < 0) i_ack_cyc = cyc;
            end
            if (exp_dack) begin
                d_pend = 1'b0;
                if (d_ack_cyc < 0) d_ack_cyc = cyc;
            end
            exp_iack = 1'b0;
            exp_dack = 1'b0;

            // memory side
            bus.m_ready  = 1'b0;
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = $urandom;
            if (exp_mreq) begin
                if (ready_cnt == 0) begin
                    bus.m_ready = 1'b1;
                    exp_mreq    = 1'b0;
                    in_wait     = 1'b1;
                    rv_cnt      = pick_delay(fixed_rv);
                end else begin
                    ready_cnt--;
                end
            end else if (in_wait) begin
                if (rv_cnt == 0) begin
                    bus.m_rvalid = 1'b1;
                    in_wait      = 1'b0;
                    if (exp_we) begin
                        w = mem_rd(exp_addr);
                        for (int b = 0; b < 4; b++)
                            if (exp_wstrb[b]) w[8*b +: 8] = exp_wdata[8*b +: 8];
                        mem[exp_addr] = w;
                    end else begin
                        bus.m_rdata = mem_rd(exp_addr);
                        if (own_d) exp_drdata = bus.m_rdata;
                        else       exp_irdata = bus.m_rdata;
                    end
                    if (own_d) exp_dack = 1'b1;
                    else       exp_iack = 1'b1;
                    free_cnt = 2;
                end else begin
                    rv_cnt--;
                end
            end else if (noise) begin
                bus.m_ready = ($urandom_range(0, 3) == 0);
            end

            // requesters: start a new access when free (possibly right after an ack)
            if (!i_pend && ($urandom_range(1, 100) <= pct_i)) begin
                i_pend   = 1'b1;
                i_addr_v = rand_addr();
            end
            if (!d_pend && ($urandom_range(1, 100) <= pct_d)) begin
                d_pend    = 1'b1;
                d_we_v    = 1'($urandom);
                d_addr_v  = rand_addr();
                d_wdata_v = $urandom;
                d_wstrb_v = 4'($urandom);
            end
            bus.i_req   = i_pend;
            bus.i_addr  = i_pend ? i_addr_v : $urandom;
            bus.d_req   = d_pend;
            bus.d_we    = d_pend ? d_we_v : 1'($urandom);
            bus.d_addr  = d_pend ? d_addr_v : $urandom;
            bus.d_wdata = d_pend ? d_wdata_v : $urandom;
            bus.d_wstrb = d_pend ? d_wstrb_v : 4'($urandom);

            // grant decision made by an idle arbiter at the coming edge
            if (arb_free && (i_pend || d_pend)) begin
                own_d = d_pend && !(GUARD && i_pend && (d_streak == LIMIT));
                if (own_d) d_streak = i_pend ? d_streak + 1 : 0;
                else       d_streak = 0;
                grant_log.push_back(own_d);
                exp_we    = own_d ? d_we_v : 1'b0;
                exp_addr  = own_d ? d_addr_v : i_addr_v;
                exp_wdata = (own_d && d_we_v) ? d_wdata_v : 32'h0;
                exp_wstrb = (own_d && d_we_v) ? d_wstrb_v : 4'h0;
                exp_mreq  = 1'b1;
                arb_free  = 1'b0;
                ready_cnt = pick_delay(fixed_ready);
            end
        end
    endtask

    initial begin
        int start;
        int first_i;
        cyc = 0;

        // 1: I-only read on a zero-wait bus
        bench_reset();
        mem[32'h100] = 32'hDEADBEEF;
        zero_wait = 1'b1;
        i_pend = 1'b1; i_addr_v = 32'h100;
        start = cyc + 1;
        run(6);
        chk("t1_ack_latency", 64'(i_ack_cyc - start), 64'(3));
        chk("t1_i_rdata", 64'(bus.i_rdata), 64'(32'hDEADBEEF));

        // 2: simultaneous D write and I read; D first
        bench_reset();
        zero_wait = 1'b1;
        d_pend = 1'b1; d_we_v = 1'b1; d_addr_v = 32'h200; d_wdata_v = 32'h55; d_wstrb_v = 4'h1;
        i_pend = 1'b1; i_addr_v = 32'h104;
        start = cyc + 1;
        run(10);
        chk("t2_grants", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() >= 2) begin
            chk("t2_first_is_d",  64'(grant_log[0]), 64'(1'b1));
            chk("t2_second_is_i", 64'(grant_log[1]), 64'(1'b0));
        end
        chk("t2_d_ack_latency", 64'(d_ack_cyc - start), 64'(3));
        chk("t2_i_ack_latency", 64'(i_ack_cyc - start), 64'(7));
        chk("t2_mem_written", 64'(mem_rd(32'h200) & 32'hFF), 64'(32'h55));

        // 3: bus holds m_ready low for 5 cycles
        bench_reset();
        fixed_ready = 5; fixed_rv = 0;
        i_pend = 1'b1; i_addr_v = 32'h108;
        start = cyc + 1;
        run(12);
        chk("t3_ack_latency", 64'(i_ack_cyc - start), 64'(8));

        // 5: both requesting continuously
        bench_reset();
        zero_wait = 1'b1;
        pct_i = 100; pct_d = 100;
        run(60);
        first_i = -1;
        foreach (grant_log[k]) if (first_i < 0 && !grant_log[k]) first_i = k;
        chk("t5_grant_count", 64'(grant_log.size()), 64'(15));
        chk("t5_first_i_grant", 64'(first_i), 64'(GUARD ? LIMIT : -1));

        // random traffic with random bus delays and stray m_ready
        bench_reset();
        pct_i = 30; pct_d = 30; noise = 1'b1;
        run(1500);
        chk("rand_progress", 64'(grant_log.size() > 100), 64'(1'b1));

        // 6: stray m_rvalid in IDLE sets sticky err; arbiter keeps working
        bench_reset();
        run(2);
        @(negedge clk);
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        bus.m_rvalid = 1'b0;
        chk("t6_err_set", 64'(bus.err), 64'(1'b1));
        chk("t6_idle_mreq", 64'(bus.m_req), 64'(1'b0));
        exp_err = 1'b1;
        run(3);
        pct_i = 50; pct_d = 50;
        run(200);

        // 4: reset in WAIT, then a late response
        bench_reset();
        fixed_ready = 0; fixed_rv = 20;
        d_pend = 1'b1; d_we_v = 1'b0; d_addr_v = 32'h10C;
        run(3);
        #2 rst = 1'b1;
        drive_idle();
        #1;
        chk("t4_rst_mreq",  64'(bus.m_req),  64'(1'b0));
        chk("t4_rst_cmd",   64'({bus.m_we, bus.m_addr, bus.m_wstrb}), 64'(0));
        chk("t4_rst_wdata", 64'(bus.m_wdata), 64'(0));
        chk("t4_rst_acks",  64'({bus.i_ack, bus.d_ack, bus.err}), 64'(0));
        chk("t4_rst_rdata", 64'({bus.i_rdata, bus.d_rdata}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hA5A5A5A5;
        @(negedge clk);
        bus.m_rvalid = 1'b0;
        chk("t4_err",     64'(bus.err),   64'(1'b1));
        chk("t4_no_dack", 64'(bus.d_ack), 64'(1'b0));
        chk("t4_no_iack", 64'(bus.i_ack), 64'(1'b0));
        chk("t4_d_rdata", 64'(bus.d_rdata), 64'(0));
        @(negedge clk);
        chk("t4_err_sticky", 64'(bus.err),   64'(1'b1));
        chk("t4_idle_mreq",  64'(bus.m_req), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
